// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pipe
//  Description : Instruction-decode stage with register file, load-use hazard
//                detection, optional WB-to-ID bypass and the ID/EX pipeline
//                register.
//  Ports       : clk, rst_n (async, active-low)
//                if_valid/pc_if/instr_if : instruction held in IF/ID
//                flush                   : squash the ID contents
//                wb_we/wb_rd/wb_data     : register-file write port
//                id_stall                : hold PC and IF/ID (combinational)
//                ex_*                    : registered ID/EX fields
//                stall_cnt               : saturating count of stall cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_valid,
    input  logic [XLEN-1:0]          pc_if,
    input  logic [31:0]              instr_if,
    input  logic                     flush,
    input  logic                     wb_we,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     id_stall,
    output logic                     ex_valid,
    output logic                     ex_RegWrite,
    output logic                     ex_MemtoReg,
    output logic                     ex_MemRead,
    output logic                     ex_MemWrite,
    output logic                     ex_ALUSrc,
    output logic                     ex_Branch,
    output logic                     ex_illegal,
    output logic [1:0]               ex_ALUop,
    output logic [2:0]               ex_funct3,
    output logic                     ex_funct7b5,
    output logic [XLEN-1:0]          ex_pc,
    output logic [XLEN-1:0]          ex_imm,
    output logic [XLEN-1:0]          ex_rs1_data,
    output logic [XLEN-1:0]          ex_rs2_data,
    output logic [$clog2(NREGS)-1:0] ex_rs1,
    output logic [$clog2(NREGS)-1:0] ex_rs2,
    output logic [$clog2(NREGS)-1:0] ex_rd,
    output logic [15:0]              stall_cnt
);

    localparam int RA = $clog2(NREGS);

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i_alu  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    logic [XLEN-1:0] r_regs [NREGS];

    logic [4:0]      w_rd_f, w_rs1_f, w_rs2_f;
    logic [RA-1:0]   w_rd, w_rs1, w_rs2;
    logic            w_reg_write, w_mem_to_reg, w_mem_read, w_mem_write;
    logic            w_alu_src, w_branch, w_illegal, w_use1, w_use2;
    logic [1:0]      w_alu_op;
    logic [XLEN-1:0] w_imm, w_rs1_data, w_rs2_data;
    logic            w_hazard, w_bubble;

    assign w_rd_f  = instr_if[11:7];
    assign w_rs1_f = instr_if[19:15];
    assign w_rs2_f = instr_if[24:20];
    assign w_rd    = w_rd_f[RA-1:0];
    assign w_rs1   = w_rs1_f[RA-1:0];
    assign w_rs2   = w_rs2_f[RA-1:0];

    // Opcode decode and immediate generation
    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        w_use1       = 1'b0;
        w_use2       = 1'b0;
        w_alu_op     = 2'b00;
        w_imm        = '0;
        case (instr_if[6:0])
            c_op_r: begin
                w_reg_write = 1'b1;
                w_alu_op    = 2'b10;
                w_use1      = 1'b1;
                w_use2      = 1'b1;
            end
            c_op_i_alu: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_op    = 2'b11;
                w_use1      = 1'b1;
                w_imm       = {{(XLEN-12){instr_if[31]}}, instr_if[31:20]};
            end
            c_op_load: begin
                w_reg_write  = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_alu_src    = 1'b1;
                w_use1       = 1'b1;
                w_imm        = {{(XLEN-12){instr_if[31]}}, instr_if[31:20]};
            end
            c_op_store: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
                w_use1      = 1'b1;
                w_use2      = 1'b1;
                w_imm       = {{(XLEN-12){instr_if[31]}}, instr_if[31:25], instr_if[11:7]};
            end
            c_op_branch: begin
                w_branch = 1'b1;
                w_alu_op = 2'b01;
                w_use1   = 1'b1;
                w_use2   = 1'b1;
                w_imm    = {{(XLEN-12){instr_if[31]}}, instr_if[7], instr_if[30:25],
                            instr_if[11:8], 1'b0};
            end
            default: w_illegal = 1'b1;
        endcase

        // A 16-entry file cannot address x16..x31: any referenced field with
        // bit 4 set turns the instruction into an illegal one.
        if (NREGS == 16 && !w_illegal &&
            ((w_reg_write && w_rd_f[4]) || (w_use1 && w_rs1_f[4]) || (w_use2 && w_rs2_f[4]))) begin
            w_reg_write  = 1'b0;
            w_mem_to_reg = 1'b0;
            w_mem_read   = 1'b0;
            w_mem_write  = 1'b0;
            w_alu_src    = 1'b0;
            w_branch     = 1'b0;
            w_alu_op     = 2'b00;
            w_imm        = '0;
            w_illegal    = 1'b1;
        end
    end

    // Register reads; a same-cycle write-back is forwarded when BYPASS is set
    assign w_rs1_data = (w_rs1 == '0) ? '0 :
                        ((BYPASS != 0) && wb_we && (wb_rd == w_rs1)) ? wb_data : r_regs[w_rs1];
    assign w_rs2_data = (w_rs2 == '0) ? '0 :
                        ((BYPASS != 0) && wb_we && (wb_rd == w_rs2)) ? wb_data : r_regs[w_rs2];

    // Load-use: the load in EX has not produced its data yet
    assign w_hazard = if_valid & ex_valid & ex_MemRead & (ex_rd != '0) &
                      ((w_use1 & (ex_rd == w_rs1)) | (w_use2 & (ex_rd == w_rs2)));
    // Flush wins: the stalled instruction is wrong-path anyway
    assign id_stall = w_hazard & ~flush;
    assign w_bubble = flush | w_hazard | ~if_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (wb_we && (wb_rd != '0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_ALUop    <= 2'b00;
            ex_funct3   <= 3'b000;
            ex_funct7b5 <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else begin
            ex_valid    <= ~w_bubble;
            ex_RegWrite <= ~w_bubble & w_reg_write;
            ex_MemtoReg <= ~w_bubble & w_mem_to_reg;
            ex_MemRead  <= ~w_bubble & w_mem_read;
            ex_MemWrite <= ~w_bubble & w_mem_write;
            ex_ALUSrc   <= ~w_bubble & w_alu_src;
            ex_Branch   <= ~w_bubble & w_branch;
            ex_illegal  <= ~w_bubble & w_illegal;
            ex_ALUop    <= w_bubble ? 2'b00 : w_alu_op;
            // Data fields are don't-care in a bubble; load them unconditionally
            ex_funct3   <= instr_if[14:12];
            ex_funct7b5 <= instr_if[30];
            ex_pc       <= pc_if;
            ex_imm      <= w_imm;
            ex_rs1_data <= w_rs1_data;
            ex_rs2_data <= w_rs2_data;
            ex_rs1      <= w_rs1;
            ex_rs2      <= w_rs2;
            ex_rd       <= w_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if (id_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end

endmodule
`default_nettype wire
